// File: rtl/conv_tile_scheduler.sv
// Layer sequencer for the 8x8 systolic convolution path: runs output-channel tiles
// through weight load, activation stream and array drain, one tile at a time.
module conv_tile_scheduler #(
  parameter int CH_W    = 12,
  parameter int DRAIN_W = 16,
  parameter int LANES   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [CH_W-1:0]    cfg_out_channel,
  input  logic [DRAIN_W-1:0] cfg_drain_cycles,
  output logic               wgt_start,
  input  logic               wgt_cached,
  output logic               act_start,
  input  logic               layer_end,
  output logic [LANES-1:0]   lane_mask,
  output logic [CH_W-1:0]    tile_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE, W_START, W_WAIT, A_START, A_WAIT, DRAIN, NEXT, FIN
  } state_t;

  state_t state, state_next;

  logic [CH_W-1:0]    n_tiles;
  logic [2:0]         rem;
  logic [DRAIN_W-1:0] drain_cfg;
  logic [DRAIN_W-1:0] drain_cnt;
  logic               wgt_prev;
  logic               layer_prev;

  logic               wgt_rise;
  logic               layer_rise;
  logic [CH_W:0]      ch_plus;
  logic [CH_W-1:0]    start_tiles;
  logic               is_last;
  logic               next_is_last;

  // One extra bit keeps the +7 round-up from wrapping before the divide by 8.
  assign ch_plus      = {1'b0, cfg_out_channel} + (CH_W+1)'(7);
  assign start_tiles  = CH_W'(ch_plus >> 3);
  assign wgt_rise     = wgt_cached & ~wgt_prev;
  assign layer_rise   = layer_end & ~layer_prev;
  assign is_last      = (tile_idx == n_tiles - CH_W'(1));
  assign next_is_last = (tile_idx + CH_W'(1) == n_tiles - CH_W'(1));

  function automatic logic [LANES-1:0] mask_for(input logic last, input logic [2:0] r);
    if (last && (r != 3'd0))
      return (LANES'(1) << r) - LANES'(1);
    else
      return '1;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (start_tiles == '0) ? FIN : W_START;
      W_START: state_next = W_WAIT;
      W_WAIT:  if (wgt_rise) state_next = A_START;
      A_START: state_next = A_WAIT;
      A_WAIT:  if (layer_rise) state_next = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_next = NEXT;
      NEXT:    state_next = is_last ? FIN : W_START;
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      n_tiles    <= '0;
      rem        <= '0;
      drain_cfg  <= '0;
      drain_cnt  <= '0;
      wgt_prev   <= 1'b0;
      layer_prev <= 1'b0;
      wgt_start  <= 1'b0;
      act_start  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      lane_mask  <= '0;
      tile_idx   <= '0;
    end else begin
      state      <= state_next;
      wgt_prev   <= wgt_cached;
      layer_prev <= layer_end;
      wgt_start  <= (state_next == W_START);
      act_start  <= (state_next == A_START);
      done       <= (state_next == FIN);
      busy       <= (state_next != IDLE);

      case (state)
        IDLE: if (start) begin
          n_tiles   <= start_tiles;
          rem       <= cfg_out_channel[2:0];
          drain_cfg <= cfg_drain_cycles;
          if (start_tiles != '0) tile_idx <= '0;
        end
        A_WAIT: if (layer_rise) drain_cnt <= drain_cfg;
        DRAIN:  if (drain_cnt != '0) drain_cnt <= drain_cnt - DRAIN_W'(1);
        NEXT:   if (!is_last) tile_idx <= tile_idx + CH_W'(1);
        default: ;
      endcase

      if (state_next == IDLE || state_next == FIN)
        lane_mask <= '0;
      else if (state == IDLE)
        lane_mask <= mask_for(start_tiles == CH_W'(1), cfg_out_channel[2:0]);
      else if (state == NEXT)
        lane_mask <= mask_for(next_is_last, rem);
    end
  end

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: lockstep handshake driver with a
// tile/mask/timing model derived from channel count and drain length.
module tb_conv_tile_scheduler;

  localparam int CH_W    = 12;
  localparam int DRAIN_W = 16;
  localparam int LANES   = 8;

  logic               clk;
  logic               reset;
  logic               start;
  logic [CH_W-1:0]    cfg_out_channel;
  logic [DRAIN_W-1:0] cfg_drain_cycles;
  logic               wgt_start;
  logic               wgt_cached;
  logic               act_start;
  logic               layer_end;
  logic [LANES-1:0]   lane_mask;
  logic [CH_W-1:0]    tile_idx;
  logic               busy;
  logic               done;

  int checks = 0;
  int errors = 0;
  int n_wgt, n_act, n_done;

  conv_tile_scheduler #(.CH_W(CH_W), .DRAIN_W(DRAIN_W), .LANES(LANES)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_out_channel(cfg_out_channel), .cfg_drain_cycles(cfg_drain_cycles),
    .wgt_start(wgt_start), .wgt_cached(wgt_cached),
    .act_start(act_start), .layer_end(layer_end),
    .lane_mask(lane_mask), .tile_idx(tile_idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Advance one clock edge; outputs are then stable until the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (wgt_start) n_wgt++;
    if (act_start) n_act++;
    if (done)      n_done++;
  endtask

  function automatic logic [7:0] modelMask(input int ch, input int t);
    int left;
    left = ch - 8 * t;
    if (left >= 8) return 8'hFF;
    return 8'((1 << left) - 1);
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_wgt"}, wgt_start, 0);
    checkOutput({tag, "_act"}, act_start, 0);
    checkOutput({tag, "_done"}, done, 0);
    checkOutput({tag, "_mask"}, lane_mask, 0);
    checkOutput({tag, "_tile"}, tile_idx, 0);
  endtask

  // Runs one layer; abort_tile >= 0 pulls reset during that tile's activation wait.
  task automatic applyStimulus(input int ch, input int drain, input bit level,
                               input bit spam, input bit probe_le, input int abort_tile);
    int tiles;
    tiles = (ch + 7) / 8;
    n_wgt = 0; n_act = 0; n_done = 0;
    cfg_out_channel  = CH_W'(ch);
    cfg_drain_cycles = DRAIN_W'(drain);
    start = 1'b1;
    tick();
    start = spam;
    cfg_out_channel  = CH_W'($urandom);
    cfg_drain_cycles = DRAIN_W'($urandom);

    if (tiles == 0) begin
      checkOutput("zero_done", done, 1);
      checkOutput("zero_busy", busy, 1);
      checkOutput("zero_wgt", wgt_start, 0);
      checkOutput("zero_mask", lane_mask, 0);
      start = 1'b0;
      tick();
      checkOutput("zero_busy_after", busy, 0);
      checkOutput("zero_done_after", done, 0);
      return;
    end

    for (int t = 0; t < tiles; t++) begin
      checkOutput("wgt_start", wgt_start, 1);
      checkOutput("tile_idx", tile_idx, t);
      checkOutput("lane_mask", lane_mask, modelMask(ch, t));
      checkOutput("busy", busy, 1);
      tick();
      checkOutput("wgt_pulse", wgt_start, 0);

      if (probe_le) begin
        layer_end = 1'b1;
        tick();
        layer_end = 1'b0;
        checkOutput("le_in_wwait", act_start, 0);
      end
      if (level && wgt_cached) begin
        tick();
        checkOutput("level_no_retrig", act_start, 0);
        wgt_cached = 1'b0;
        tick();
        checkOutput("level_low", act_start, 0);
      end
      repeat ($urandom_range(0, 3)) begin
        tick();
        checkOutput("w_wait_act", act_start, 0);
      end

      wgt_cached = 1'b1;
      tick();
      checkOutput("act_latency", act_start, 1);
      checkOutput("tile_stable", tile_idx, t);
      if (!level) wgt_cached = 1'b0;
      tick();
      checkOutput("act_pulse", act_start, 0);

      if (t == abort_tile) begin
        reset = 1'b0;
        tick();
        checkAllZero("abort");
        wgt_cached = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checkOutput("abort_no_done", n_done, 0);
        checkOutput("abort_idle", busy, 0);
        return;
      end

      repeat ($urandom_range(0, 4)) begin
        tick();
        checkOutput("a_wait_quiet", wgt_start | done, 0);
      end
      layer_end = 1'b1;
      tick();
      layer_end = 1'b0;
      for (int k = 0; k <= drain; k++) begin
        tick();
        checkOutput("drain_quiet", wgt_start | done, 0);
      end
      tick();
      if (t == tiles - 1) begin
        checkOutput("done_timing", done, 1);
        checkOutput("done_busy", busy, 1);
        checkOutput("fin_mask", lane_mask, 0);
        start = 1'b0;
      end
    end

    wgt_cached = 1'b0;
    tick();
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("n_wgt", n_wgt, tiles);
    checkOutput("n_act", n_act, tiles);
    checkOutput("n_done", n_done, 1);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    wgt_cached = 1'b0;
    layer_end = 1'b0;
    cfg_out_channel = '0;
    cfg_drain_cycles = '0;
    repeat (5) tick();
    checkAllZero("reset");
    reset = 1'b1;
    tick();

    $display("[TB] abort during tile 1");
    applyStimulus(35, 20, 0, 0, 0, 1);
    $display("[TB] full layer 35ch drain 20");
    applyStimulus(35, 20, 0, 0, 0, -1);
    $display("[TB] level-held handshakes");
    applyStimulus(20, 3, 1, 0, 0, -1);
    $display("[TB] boundary configs");
    applyStimulus(0, 4, 0, 0, 0, -1);
    applyStimulus(8, 5, 0, 0, 0, -1);
    applyStimulus(13, 0, 0, 0, 0, -1);
    $display("[TB] ignored inputs");
    applyStimulus(16, 2, 0, 1, 0, -1);
    applyStimulus(24, 1, 0, 0, 1, -1);
    $display("[TB] randomized layers");
    for (int i = 0; i < 8; i++)
      applyStimulus($urandom_range(0, 45), $urandom_range(0, 6), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
